scan_ctrl4: RTL and testbench



---
 rtl/scan_ctrl4.sv | 138 +++++++++++++
 tb/tb_scan_ctrl4.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_ctrl4.sv
// ============================================================================
// scan_ctrl4 : 4-digit display scan sequencer (mux select, anodes, snapshot)
// Optional macro SCAN_CTRL4_LZB_EN enables leading-zero blanking.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_ctrl4 #(
    parameter int ANCHO = 4,
    parameter int DIV   = 50000,
    parameter int GUARD = 500,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [ANCHO-1:0] d0,
    input  logic [ANCHO-1:0] d1,
    input  logic [ANCHO-1:0] d2,
    input  logic [ANCHO-1:0] d3,
    output logic [ANCHO-1:0] q0,
    output logic [ANCHO-1:0] q1,
    output logic [ANCHO-1:0] q2,
    output logic [ANCHO-1:0] q3,
    output logic [1:0]       sel,
    output logic [3:0]       an,
    output logic             frame_start
);

    localparam logic [CW-1:0] c_last     = CW'(DIV - 1);
    localparam logic [CW-1:0] c_guard_m1 = CW'(GUARD - 1);

    localparam logic [0:0] S_GUARD = 1'b0;
    localparam logic [0:0] S_SHOW  = 1'b1;

    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_sel;
    logic [0:0]       r_state;
    logic [3:0]       r_an;
    logic             r_fs;
    logic             r_restart;
    logic [ANCHO-1:0] r_q0, r_q1, r_q2, r_q3;

    logic [CW-1:0]    w_cnt_next;
    logic [1:0]       w_sel_next;
    logic [0:0]       w_state_next;
    logic [3:0]       w_an_next;
    logic             w_wrap;
    logic             w_load;
    logic [3:0]       w_blank;
    logic [ANCHO-1:0] w_qn0, w_qn1, w_qn2, w_qn3;

    assign w_wrap = en && (r_cnt == c_last);

    // Snapshot on a slot-0 entry: normal wrap out of slot 3, or the first
    // enabled edge after reset / an enable drop while parked on slot 0.
    assign w_load = en && ((r_restart && (r_sel == 2'd0)) ||
                           (w_wrap && (r_sel == 2'd3)));

    assign w_cnt_next = (!en || w_wrap) ? {CW{1'b0}} : r_cnt + CW'(1);
    assign w_sel_next = w_wrap ? r_sel + 2'd1 : r_sel;

    assign w_qn0 = w_load ? d0 : r_q0;
    assign w_qn1 = w_load ? d1 : r_q1;
    assign w_qn2 = w_load ? d2 : r_q2;
    assign w_qn3 = w_load ? d3 : r_q3;

`ifdef SCAN_CTRL4_LZB_EN
    assign w_blank[3] = (w_qn3 == '0);
    assign w_blank[2] = w_blank[3] && (w_qn2 == '0);
    assign w_blank[1] = w_blank[2] && (w_qn1 == '0);
    assign w_blank[0] = 1'b0;
`else
    assign w_blank = 4'b0000;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_GUARD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (!en || w_wrap) begin
            w_state_next = S_GUARD;
        end else if (r_cnt == c_guard_m1) begin
            w_state_next = S_SHOW;
        end
    end

    // Output logic: anode pattern for the coming cycle
    always_comb begin
        w_an_next = 4'b1111;
        if ((w_state_next == S_SHOW) && !w_blank[w_sel_next]) begin
            w_an_next[w_sel_next] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= {CW{1'b0}};
            r_sel     <= 2'd0;
            r_an      <= 4'b1111;
            r_fs      <= 1'b0;
            r_restart <= 1'b1;
            r_q0      <= '0;
            r_q1      <= '0;
            r_q2      <= '0;
            r_q3      <= '0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_sel     <= w_sel_next;
            r_an      <= w_an_next;
            r_fs      <= w_load;
            r_restart <= !en;
            r_q0      <= w_qn0;
            r_q1      <= w_qn1;
            r_q2      <= w_qn2;
            r_q3      <= w_qn3;
        end
    end

    assign q0          = r_q0;
    assign q1          = r_q1;
    assign q2          = r_q2;
    assign q3          = r_q3;
    assign sel         = r_sel;
    assign an          = r_an;
    assign frame_start = r_fs;

endmodule

`default_nettype wire

// File: tb/tb_scan_ctrl4.sv
// ============================================================================
// tb_scan_ctrl4 : self-checking bench for scan_ctrl4 with a slot-time model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_ctrl4;

    localparam int ANCHO = 4;
    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int CW    = 4;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [ANCHO-1:0] d0, d1, d2, d3;
    logic [ANCHO-1:0] q0, q1, q2, q3;
    logic [1:0]       sel;
    logic [3:0]       an;
    logic             frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    scan_ctrl4 #(.ANCHO(ANCHO), .DIV(DIV), .GUARD(GUARD), .CW(CW)) u_dut (
        .clk(clk), .reset_n(rst_n), .en(en),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .sel(sel), .an(an), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time within the current slot, slot index, frame snapshot.
    int               m_t;
    int               m_s;
    logic [ANCHO-1:0] m_snap [4];
    logic             m_fs;
    logic             m_fresh;

    always @(posedge clk or negedge rst_n) begin : p_model
        int               nt, ns;
        logic             nfs, nfresh;
        logic [ANCHO-1:0] nsnap [4];
        if (!rst_n) begin
            nt = 0; ns = 0; nfs = 1'b0; nfresh = 1'b1;
            for (int k = 0; k < 4; k++) nsnap[k] = '0;
        end else begin
            nt = m_t; ns = m_s; nfs = 1'b0; nfresh = m_fresh;
            for (int k = 0; k < 4; k++) nsnap[k] = m_snap[k];
            if (!en) begin
                nt = 0;
                nfresh = 1'b1;
            end else begin
                if (m_fresh && (m_s == 0)) begin
                    nsnap[0] = d0; nsnap[1] = d1; nsnap[2] = d2; nsnap[3] = d3;
                    nfs = 1'b1;
                end
                nfresh = 1'b0;
                nt = m_t + 1;
                if (nt == DIV) begin
                    nt = 0;
                    ns = (m_s + 1) % 4;
                    if (ns == 0) begin
                        nsnap[0] = d0; nsnap[1] = d1; nsnap[2] = d2; nsnap[3] = d3;
                        nfs = 1'b1;
                    end
                end
            end
        end
        m_t     <= nt;
        m_s     <= ns;
        m_fs    <= nfs;
        m_fresh <= nfresh;
        for (int k = 0; k < 4; k++) m_snap[k] <= nsnap[k];
    end

    function automatic logic [3:0] exp_an();
        logic lz;
        if (m_t < GUARD) return 4'b1111;
`ifdef SCAN_CTRL4_LZB_EN
        // A digit is dark when it and every more-significant digit are zero.
        lz = (m_s != 0);
        for (int k = m_s; k < 4; k++) if (m_snap[k] != '0) lz = 1'b0;
        if (lz) return 4'b1111;
`else
        lz = 1'b0;
        if (lz) return 4'b1111;
`endif
        return ~(4'b0001 << m_s);
    endfunction

    always @(negedge clk) begin : p_compare
        check("an",          {28'd0, an},           {28'd0, exp_an()});
        check("sel",         {30'd0, sel},          m_s);
        check("frame_start", {31'd0, frame_start},  {31'd0, m_fs});
        check("q",           {16'd0, q3, q2, q1, q0},
                             {16'd0, m_snap[3], m_snap[2], m_snap[1], m_snap[0]});
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [ANCHO-1:0] rnd_dig();
        if ($urandom_range(0, 2) == 0) return '0;
        return ANCHO'($urandom_range(0, 15));
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        wait_neg(2);
        check("rst_an",  {28'd0, an}, 32'hF);
        check("rst_sel", {30'd0, sel}, 32'd0);
        check("rst_q",   {16'd0, q3, q2, q1, q0}, 32'd0);
        check("rst_fs",  {31'd0, frame_start}, 32'd0);

        rst_n = 1'b1; en = 1'b1;
        d0 = 4'd3; d1 = 4'd2; d2 = 4'd1; d3 = 4'd0;
        wait_neg(1);
        check("first_fs", {31'd0, frame_start}, 32'd1);
        check("first_q0", {28'd0, q0}, 32'd3);
        check("first_guard_an", {28'd0, an}, 32'hF);
        wait_neg(1);
        check("slot0_an", {28'd0, an}, 32'hE);
        check("slot0_fs", {31'd0, frame_start}, 32'd0);
        wait_neg(6);
        check("slot1_sel", {30'd0, sel}, 32'd1);
        check("slot1_guard_an", {28'd0, an}, 32'hF);
        wait_neg(2);
        check("slot1_an", {28'd0, an}, 32'hD);

        en = 1'b0;
        wait_neg(5);
        check("en_off_an",  {28'd0, an}, 32'hF);
        check("en_off_sel", {30'd0, sel}, 32'd1);
        en = 1'b1;
        wait_neg(1);
        check("en_back_guard", {28'd0, an}, 32'hF);
        wait_neg(1);
        check("en_back_show", {28'd0, an}, 32'hD);
        wait_neg(5);
        check("en_back_show_end", {28'd0, an}, 32'hD);
        wait_neg(1);
        check("slot2_sel", {30'd0, sel}, 32'd2);

        d0 = 4'd7;
        wait_neg(3);
        check("q0_held", {28'd0, q0}, 32'd3);
        check("slot2_an", {28'd0, an}, 32'hB);
        wait_neg(13);
        check("q0_new", {28'd0, q0}, 32'd7);
        check("frame_fs", {31'd0, frame_start}, 32'd1);
        wait_neg(19);
        check("pre_rst_an", {28'd0, an}, 32'hB);
        #3 rst_n = 1'b0;
        #1;
        check("async_an",  {28'd0, an}, 32'hF);
        check("async_sel", {30'd0, sel}, 32'd0);
        check("async_q",   {16'd0, q3, q2, q1, q0}, 32'd0);
        @(negedge clk);

        rst_n = 1'b1;
        d0 = 4'd0; d1 = 4'd4; d2 = 4'd0; d3 = 4'd0;
        wait_neg(2);
        check("lz_d0_an", {28'd0, an}, 32'hE);
        wait_neg(8);
        check("lz_d1_an", {28'd0, an}, 32'hD);
        wait_neg(8);
`ifdef SCAN_CTRL4_LZB_EN
        check("lz_d2_an", {28'd0, an}, 32'hF);
`else
        check("lz_d2_an", {28'd0, an}, 32'hB);
`endif
        wait_neg(8);
`ifdef SCAN_CTRL4_LZB_EN
        check("lz_d3_an", {28'd0, an}, 32'hF);
`else
        check("lz_d3_an", {28'd0, an}, 32'h7);
`endif
        d1 = 4'd0;
        wait_neg(8);
        check("zero_d0_an", {28'd0, an}, 32'hE);
        wait_neg(8);
`ifdef SCAN_CTRL4_LZB_EN
        check("zero_d1_an", {28'd0, an}, 32'hF);
`else
        check("zero_d1_an", {28'd0, an}, 32'hD);
`endif

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                d0 = rnd_dig(); d1 = rnd_dig(); d2 = rnd_dig(); d3 = rnd_dig();
            end
            en = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
